// File: rtl/serial_link_autostart.sv
// Hardware bring-up/teardown sequencer for one serial link instance.
// Optional bring-up latency counter enabled by SERIAL_LINK_AUTOSTART_STATS_EN.
module serial_link_autostart #(
    parameter int unsigned NumChannels   = 1,
    parameter int unsigned RstCycles     = 16,
    parameter int unsigned SettleCycles  = 50,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned MaxRetries    = 3,
    parameter int unsigned CntWidth      = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [1:0]          isolated_i,
    output logic                link_clk_ena_o,
    output logic                link_rst_no,
    output logic [1:0]          axi_isolate_o,
    output logic                ch_alloc_bypass_o,
    output logic                ch_alloc_flush_o,
    output logic                busy_o,
    output logic                link_up_o,
    output logic                error_o,
    output logic [3:0]          retry_cnt_o,
    output logic [CntWidth-1:0] bringup_cycles_o
);

    typedef enum logic [3:0] {
        StIdle, StRstAssert, StClkEn, StRstRelease, StSettle,
        StDeisolate, StUp, StTeardown, StFail
    } state_e;

    localparam logic [CntWidth-1:0] RstLast     = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] SettleLast  = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [3:0]          RetryMax    = 4'(MaxRetries);
    localparam logic                MultiCh     = (NumChannels > 1);

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [3:0]          retry_q, retry_d;
    logic                clk_ena_d, rst_n_d, bypass_d, busy_d, up_d, err_d;
    logic [1:0]          iso_d;
    logic                clk_ena_q, rst_n_q, bypass_q, busy_q, up_q, err_q;
    logic [1:0]          iso_q;

    // Timeout in DEISOLATE and link loss in UP share this retry decision.
    function automatic state_e retry_target(input logic [3:0] r);
        return (r < RetryMax) ? StRstAssert : StFail;
    endfunction

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRstAssert;
                    retry_d = '0;
                end
            end
            StRstAssert: begin
                if (stop_i)                state_d = StTeardown;
                else if (cnt_q == RstLast) state_d = StClkEn;
            end
            StClkEn:      state_d = stop_i ? StTeardown : StRstRelease;
            StRstRelease: state_d = stop_i ? StTeardown : StSettle;
            StSettle: begin
                if (stop_i)                   state_d = StTeardown;
                else if (cnt_q == SettleLast) state_d = StDeisolate;
            end
            StDeisolate: begin
                if (stop_i)                      state_d = StTeardown;
                else if (isolated_i == 2'b00)    state_d = StUp;
                else if (cnt_q == TimeoutLast) begin
                    state_d = retry_target(retry_q);
                    if (retry_q < RetryMax) retry_d = retry_q + 4'd1;
                end
            end
            StUp: begin
                if (stop_i) state_d = StTeardown;
                else if (isolated_i != 2'b00) begin
                    state_d = retry_target(retry_q);
                    if (retry_q < RetryMax) retry_d = retry_q + 4'd1;
                end
            end
            StTeardown: begin
                if (isolated_i == 2'b11 || cnt_q == TimeoutLast) state_d = StIdle;
            end
            StFail: begin
                if (!start_i && stop_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end

    // Outputs decoded from the next state so the registered copies track the state.
    always_comb begin
        clk_ena_d = 1'b0;
        rst_n_d   = 1'b0;
        iso_d     = 2'b11;
        bypass_d  = 1'b0;
        busy_d    = 1'b1;
        up_d      = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            StIdle:      busy_d = 1'b0;
            StRstAssert: busy_d = 1'b1;
            StClkEn: begin
                clk_ena_d = 1'b1;
                bypass_d  = MultiCh;
            end
            StRstRelease, StSettle, StTeardown: begin
                clk_ena_d = 1'b1;
                rst_n_d   = 1'b1;
                bypass_d  = MultiCh;
            end
            StDeisolate: begin
                clk_ena_d = 1'b1;
                rst_n_d   = 1'b1;
                iso_d     = 2'b00;
                bypass_d  = MultiCh;
            end
            StUp: begin
                clk_ena_d = 1'b1;
                rst_n_d   = 1'b1;
                iso_d     = 2'b00;
                bypass_d  = MultiCh;
                busy_d    = 1'b0;
                up_d      = 1'b1;
            end
            StFail: begin
                busy_d = 1'b0;
                err_d  = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            retry_q   <= '0;
            clk_ena_q <= 1'b0;
            rst_n_q   <= 1'b0;
            iso_q     <= 2'b11;
            bypass_q  <= 1'b0;
            busy_q    <= 1'b0;
            up_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            clk_ena_q <= clk_ena_d;
            rst_n_q   <= rst_n_d;
            iso_q     <= iso_d;
            bypass_q  <= bypass_d;
            busy_q    <= busy_d;
            up_q      <= up_d;
            err_q     <= err_d;
        end
    end

    assign link_clk_ena_o    = clk_ena_q;
    assign link_rst_no       = rst_n_q;
    assign axi_isolate_o     = iso_q;
    assign ch_alloc_bypass_o = bypass_q;
    assign ch_alloc_flush_o  = bypass_q;
    assign busy_o            = busy_q;
    assign link_up_o         = up_q;
    assign error_o           = err_q;
    assign retry_cnt_o       = retry_q;

`ifdef SERIAL_LINK_AUTOSTART_STATS_EN
    logic [CntWidth-1:0] stats_q, stats_d;

    // Counts every edge spent in bring-up states, across retries; holds in UP.
    always_comb begin
        stats_d = stats_q;
        if (state_q == StIdle && state_d != StIdle) begin
            stats_d = '0;
        end else if (state_q inside {StRstAssert, StClkEn, StRstRelease, StSettle, StDeisolate}
                     && stats_q != '1) begin
            stats_d = stats_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stats_q <= '0;
        else       stats_q <= stats_d;
    end

    assign bringup_cycles_o = stats_q;
`else
    assign bringup_cycles_o = '0;
`endif

endmodule

// File: tb/tb_serial_link_autostart.sv
// Scoreboard bench for serial_link_autostart: expected event cycles are queued
// when stimulus is applied and checked when the DUT output changes.
module tb_serial_link_autostart;
    localparam int Rst    = 16;
    localparam int Settle = 50;
    localparam int Tmo    = 32;
    localparam int MaxR   = 3;
    localparam int CntW   = 16;
    localparam int Lag    = 5;
`ifdef SERIAL_LINK_AUTOSTART_STATS_EN
    localparam int StatsExp = Rst + Settle + 3 + Lag;
`else
    localparam int StatsExp = 0;
`endif
    // {clk_ena, rst_no, isolate[1:0], bypass, flush, busy, up, error, retry[3:0]}
    localparam logic [12:0] RstVec = 13'b0_0_11_0_0_0_0_0_0000;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, stop = 1'b0;
    logic [1:0] iso = 2'b11;

    logic a_clk, a_rstn, a_bypass, a_flush, a_busy, a_up, a_err;
    logic [1:0] a_iso;
    logic [3:0] a_retry;
    logic [CntW-1:0] a_stats;
    logic b_clk, b_rstn, b_bypass, b_flush, b_busy, b_up, b_err;
    logic [1:0] b_iso;
    logic [3:0] b_retry;
    logic [CntW-1:0] b_stats;

    typedef struct {string name; int val; int at;} exp_t;
    exp_t sb[$];
    logic [1:0] hist[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int b_bypass_seen = 0;

    serial_link_autostart #(
        .NumChannels(2), .RstCycles(Rst), .SettleCycles(Settle), .TimeoutCycles(Tmo),
        .MaxRetries(MaxR), .CntWidth(CntW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .isolated_i(iso),
        .link_clk_ena_o(a_clk), .link_rst_no(a_rstn), .axi_isolate_o(a_iso),
        .ch_alloc_bypass_o(a_bypass), .ch_alloc_flush_o(a_flush), .busy_o(a_busy),
        .link_up_o(a_up), .error_o(a_err), .retry_cnt_o(a_retry), .bringup_cycles_o(a_stats)
    );

    serial_link_autostart #(
        .NumChannels(1), .RstCycles(Rst), .SettleCycles(Settle), .TimeoutCycles(Tmo),
        .MaxRetries(MaxR), .CntWidth(CntW)
    ) dut_single (
        .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .isolated_i(iso),
        .link_clk_ena_o(b_clk), .link_rst_no(b_rstn), .axi_isolate_o(b_iso),
        .ch_alloc_bypass_o(b_bypass), .ch_alloc_flush_o(b_flush), .busy_o(b_busy),
        .link_up_o(b_up), .error_o(b_err), .retry_cnt_o(b_retry), .bringup_cycles_o(b_stats)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (b_bypass || b_flush) b_bypass_seen <= b_bypass_seen + 1;

    // Link model: isolation status follows the request Lag negedges later.
    task automatic follow_iso();
        hist.push_back(a_iso);
        if (hist.size() > Lag) iso = hist.pop_front();
    endtask

    task automatic test_reset();
        logic [12:0] v;
        rst = 1'b1; start = 1'b0; stop = 1'b0; iso = 2'b11;
        repeat (3) @(negedge clk);
        v = {a_clk, a_rstn, a_iso, a_bypass, a_flush, a_busy, a_up, a_err, a_retry};
        n_checks++;
        if (v !== RstVec) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", v, RstVec);
        end
        n_checks++;
        if (a_stats !== '0) begin
            n_fail++; $display("FAIL reset_stats: got %0d expected 0", a_stats);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bringup();
        exp_t e;
        int e0;
        bit done = 1'b0;
        logic p_clk, p_rstn, p_up;
        hist.delete(); iso = 2'b11; start = 1'b1;
        e0 = cyc + 1;
        sb.push_back('{"clk_ena_rise", 1, e0 + Rst});
        sb.push_back('{"rst_no_rise", 1, e0 + Rst + 1});
        sb.push_back('{"link_up_rise", 1, e0 + Rst + Settle + 3 + Lag});
        p_clk = a_clk; p_rstn = a_rstn; p_up = a_up;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            start = 1'b0;
            follow_iso();
            if (a_clk && !p_clk) begin
                n_checks++;
                if (a_bypass !== 1'b1 || a_flush !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bypass_with_clk: got %b%b expected 11", a_bypass, a_flush);
                end
            end
            if ((a_clk && !p_clk) || (a_rstn && !p_rstn) || (a_up && !p_up)) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++; $display("FAIL bringup_event: unexpected edge at cycle %0d", cyc);
                end else begin
                    e = sb.pop_front();
                    if (cyc !== e.at) begin
                        n_fail++;
                        $display("FAIL %s: seen at cycle %0d expected %0d", e.name, cyc, e.at);
                    end
                end
                done = a_up;
            end
            p_clk = a_clk; p_rstn = a_rstn; p_up = a_up;
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL bringup_timeout: link_up %b expected 1", a_up);
        end
        sb.delete();
        n_checks++;
        if (a_stats !== CntW'(StatsExp)) begin
            n_fail++; $display("FAIL bringup_stats: got %0d expected %0d", a_stats, StatsExp);
        end
        n_checks++;
        if (a_retry !== 4'd0 || a_busy !== 1'b0 || a_iso !== 2'b00) begin
            n_fail++;
            $display("FAIL up_state: retry %0d busy %b iso %b expected 0 0 00",
                     a_retry, a_busy, a_iso);
        end
    endtask

    task automatic test_link_loss();
        exp_t e;
        int e1;
        bit done = 1'b0;
        logic p_up;
        iso = 2'b01;
        e1 = cyc + 1;
        sb.push_back('{"loss_link_down", 0, e1});
        sb.push_back('{"loss_link_up", 1, e1 + Rst + Settle + 3});
        p_up = a_up;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            iso = 2'b00;
            if (a_up !== p_up) begin
                n_checks++;
                e = sb.pop_front();
                if (cyc !== e.at || a_up !== e.val[0]) begin
                    n_fail++;
                    $display("FAIL %s: up %b at cycle %0d expected %0d at %0d",
                             e.name, a_up, cyc, e.val, e.at);
                end
                n_checks++;
                if (a_retry !== 4'd1) begin
                    n_fail++; $display("FAIL loss_retry: got %0d expected 1", a_retry);
                end
                done = a_up;
            end
            p_up = a_up;
        end
        n_checks++;
        if (!done || a_err !== 1'b0) begin
            n_fail++; $display("FAIL loss_recover: up %b err %b expected 1 0", a_up, a_err);
        end
        sb.delete();
    endtask

    task automatic test_teardown();
        exp_t e;
        int s;
        bit done = 1'b0;
        stop = 1'b1; start = 1'b0;
        s = cyc;
        sb.push_back('{"teardown_clk_off", 0, s + 4});
        @(negedge clk);
        n_checks++;
        if (a_iso !== 2'b11 || a_clk !== 1'b1 || a_busy !== 1'b1 || a_up !== 1'b0) begin
            n_fail++;
            $display("FAIL teardown_entry: iso %b clk %b busy %b up %b expected 11 1 1 0",
                     a_iso, a_clk, a_busy, a_up);
        end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (cyc == s + 3) iso = 2'b11;
            if (!a_clk) begin
                n_checks++;
                e = sb.pop_front();
                if (cyc !== e.at) begin
                    n_fail++;
                    $display("FAIL %s: seen at cycle %0d expected %0d", e.name, cyc, e.at);
                end
                done = 1'b1;
            end
        end
        stop = 1'b0;
        n_checks++;
        if (!done || a_busy !== 1'b0 || a_rstn !== 1'b0) begin
            n_fail++;
            $display("FAIL teardown_idle: busy %b rst_no %b expected 0 0", a_busy, a_rstn);
        end
        sb.delete();
    endtask

    task automatic test_retry_fail();
        exp_t e;
        int e0;
        bit done = 1'b0;
        logic [3:0] p_retry;
        logic p_err;
        iso = 2'b11; start = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= MaxR; k++) sb.push_back('{"retry_step", k, e0 + k * (Rst + Settle + 2 + Tmo)});
        sb.push_back('{"fail_entry", 1, e0 + (MaxR + 1) * (Rst + Settle + 2 + Tmo)});
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (a_retry !== 4'd0) begin
            n_fail++; $display("FAIL retry_clear: got %0d expected 0", a_retry);
        end
        p_retry = a_retry; p_err = a_err;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (a_retry !== p_retry || (a_err && !p_err)) begin
                n_checks++;
                e = sb.pop_front();
                if (cyc !== e.at || (a_err ? 1 : int'(a_retry)) !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: retry %0d err %b at cycle %0d expected %0d at %0d",
                             e.name, a_retry, a_err, cyc, e.val, e.at);
                end
                done = a_err;
            end
            p_retry = a_retry; p_err = a_err;
        end
        n_checks++;
        if (!done || a_clk !== 1'b0 || a_rstn !== 1'b0 || a_iso !== 2'b11 || a_up !== 1'b0
            || a_busy !== 1'b0 || a_retry !== 4'(MaxR)) begin
            n_fail++;
            $display("FAIL fail_safe: err %b clk %b rst_no %b iso %b up %b busy %b retry %0d",
                     a_err, a_clk, a_rstn, a_iso, a_up, a_busy, a_retry);
        end
        sb.delete();
        start = 1'b1; stop = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_err !== 1'b1) begin
            n_fail++; $display("FAIL fail_sticky: err %b expected 1", a_err);
        end
        start = 1'b0;
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (a_err !== 1'b0 || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL fail_clear: err %b busy %b expected 0 0", a_err, a_busy);
        end
    endtask

    task automatic test_reset_midop();
        logic [12:0] v;
        int e0;
        iso = 2'b11; start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < e0 + 30) @(negedge clk);
        n_checks++;
        if (a_clk !== 1'b1 || a_rstn !== 1'b1 || a_busy !== 1'b1 || a_iso !== 2'b11) begin
            n_fail++;
            $display("FAIL settle_state: clk %b rst_no %b busy %b iso %b expected 1 1 1 11",
                     a_clk, a_rstn, a_busy, a_iso);
        end
        rst = 1'b1;
        @(negedge clk);
        v = {a_clk, a_rstn, a_iso, a_bypass, a_flush, a_busy, a_up, a_err, a_retry};
        n_checks++;
        if (v !== RstVec || a_stats !== '0) begin
            n_fail++;
            $display("FAIL midop_reset: got %b stats %0d expected %b stats 0", v, a_stats, RstVec);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stop_in_bringup();
        start = 1'b1; iso = 2'b11;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b1 || a_clk !== 1'b1 || a_iso !== 2'b11) begin
            n_fail++;
            $display("FAIL stop_teardown: busy %b clk %b iso %b expected 1 1 11",
                     a_busy, a_clk, a_iso);
        end
        @(negedge clk);
        stop = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_clk !== 1'b0) begin
            n_fail++; $display("FAIL stop_idle: busy %b clk %b expected 0 0", a_busy, a_clk);
        end
    endtask

    task automatic test_single_channel();
        n_checks++;
        if (b_bypass_seen !== 0) begin
            n_fail++;
            $display("FAIL single_ch_bypass: high for %0d cycles expected 0", b_bypass_seen);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_link_loss();
        test_teardown();
        test_retry_fail();
        test_reset_midop();
        test_stop_in_bringup();
        test_single_channel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
